// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Shares one single-ported 16-bit memory between an instruction-fetch port
// and a data (load/store) port. Exactly one access is in flight at a time.
// Each access walks IDLE -> ISSUE -> RESP -> IDLE. The owner's ready pulse
// appears in the IDLE cycle that follows RESP, so accesses can run back to
// back at one every three cycles.
//
// Data normally wins arbitration. A starvation counter bounds how many data
// grants in a row can pass a waiting fetch. Once it reaches STARVE_LIMIT,
// the next contested arbitration goes to the fetch.
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous, active-high reset
//   if_req     in   fetch request, held until if_ready
//   if_addr    in   fetch address [15:0]
//   if_ready   out  one-cycle pulse, fetch complete
//   if_data    out  last fetched word [15:0]
//   d_req      in   data request, held until d_ready
//   d_write    in   1 = store, 0 = load
//   d_addr     in   data address [15:0]
//   d_wdata    in   store data [15:0]
//   d_ready    out  one-cycle pulse, data access complete
//   d_rdata    out  last loaded word [15:0]
//   mem_addr   out  memory address [15:0]
//   mem_din    out  memory write data [15:0]
//   mem_write  out  memory write enable
//   mem_dout   in   memory read data [15:0], valid the cycle after the address
//   busy       out  high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic [15:0] if_data,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_write,
    input  logic [15:0] mem_dout,
    output logic        busy
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_grantData;
    logic             w_grantFetch;
    logic [CNT_W-1:0] r_starveCnt;
    logic             r_ownerFetch;
    logic             r_opWrite;
    logic [15:0]      r_memAddr;
    logic [15:0]      r_memDin;
    logic             r_memWrite;
    logic [15:0]      r_ifData;
    logic [15:0]      r_dRdata;
    logic             r_ifReady;
    logic             r_dReady;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Arbitration and next state. Requests only count in IDLE.
    // Data wins unless a fetch is also waiting and has already been passed
    // STARVE_LIMIT times.
    always_comb begin
        w_nextState  = r_state;
        w_grantData  = 1'b0;
        w_grantFetch = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && (!if_req || (r_starveCnt < LIMIT_CNT))) begin
                    w_grantData = 1'b1;
                end else if (if_req) begin
                    w_grantFetch = 1'b1;
                end
                if (w_grantData || w_grantFetch) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Starvation counter. It only measures data grants that actually passed
    // a waiting fetch. Any cycle without a fetch request, or a fetch grant,
    // clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (!if_req || w_grantFetch) begin
            r_starveCnt <= '0;
        end else if (w_grantData && (r_starveCnt != LIMIT_CNT)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

    // Access datapath.
    // The grant edge latches the address, store data, owner and operation.
    // The write enable covers only the ISSUE cycle.
    // The edge leaving RESP captures the read data and raises the owner's
    // ready in the same cycle, so ready and data are valid together.
    // A store leaves d_rdata untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_memAddr    <= 16'h0000;
            r_memDin     <= 16'h0000;
            r_memWrite   <= 1'b0;
            r_ownerFetch <= 1'b0;
            r_opWrite    <= 1'b0;
            r_ifData     <= 16'h0000;
            r_dRdata     <= 16'h0000;
            r_ifReady    <= 1'b0;
            r_dReady     <= 1'b0;
        end else begin
            r_ifReady <= 1'b0;
            r_dReady  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantData) begin
                        r_memAddr    <= d_addr;
                        r_memDin     <= d_wdata;
                        r_ownerFetch <= 1'b0;
                        r_opWrite    <= d_write;
                        r_memWrite   <= d_write;
                    end else if (w_grantFetch) begin
                        r_memAddr    <= if_addr;
                        r_ownerFetch <= 1'b1;
                        r_opWrite    <= 1'b0;
                        r_memWrite   <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_memWrite <= 1'b0;
                end
                RESP: begin
                    r_memWrite <= 1'b0;
                    if (r_ownerFetch) begin
                        r_ifData  <= mem_dout;
                        r_ifReady <= 1'b1;
                    end else begin
                        if (!r_opWrite) begin
                            r_dRdata <= mem_dout;
                        end
                        r_dReady <= 1'b1;
                    end
                end
                default: begin
                    r_memWrite <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_memAddr;
    assign mem_din   = r_memDin;
    assign mem_write = r_memWrite;
    assign if_data   = r_ifData;
    assign d_rdata   = r_dRdata;
    assign if_ready  = r_ifReady;
    assign d_ready   = r_dReady;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter. A behavioural memory returns read data
// one cycle after the address. A table of single accesses is replayed, then
// hand-written sequences cover contention, a request dropped mid-access and
// reset asserted during a store.
// Inputs change on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int STARVE_LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic [15:0] if_data;
    logic        d_req;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_write;
    logic [15:0] mem_dout;
    logic        busy;

    logic [15:0] memory [0:65535];

    int errors = 0;
    int checks = 0;

    memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .d_req     (d_req),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_write (mem_write),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Synchronous memory model. Read data follows the address by one cycle.
    always @(posedge clock) begin
        if (mem_write) begin
            memory[mem_addr] <= mem_din;
        end
        mem_dout <= memory[mem_addr];
    end

    typedef struct {
        bit          isFetch;
        bit          isWrite;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expData;
    } vector_t;

    vector_t vectors [8];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Waits for the requested owner's ready pulse. Latency is the number of
    // falling edges from the request up to the pulse. A timeout gives 99.
    task automatic waitReady(input bit wantFetch, output int lat, output int wrCnt,
                             output logic [15:0] wrAddr, output logic [15:0] wrData,
                             output int wrongReady, output logic busyEarly);
        lat = 0;
        wrCnt = 0;
        wrAddr = 16'h0000;
        wrData = 16'h0000;
        wrongReady = 0;
        busyEarly = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            lat++;
            if (lat == 1) busyEarly = busy;
            if (mem_write) begin
                wrCnt++;
                wrAddr = mem_addr;
                wrData = mem_din;
            end
            if (wantFetch ? d_ready : if_ready) wrongReady++;
            if (wantFetch ? if_ready : d_ready) return;
        end
        lat = 99;
    endtask

    // Runs one table entry as a complete access and checks it.
    task automatic applyStimulus(input int idx);
        vector_t     v;
        int          lat;
        int          wrCnt;
        int          wrongReady;
        logic [15:0] wrAddr;
        logic [15:0] wrData;
        logic        busyEarly;
        v = vectors[idx];
        @(negedge clock);
        if (v.isFetch) begin
            if_addr = v.addr;
            if_req  = 1'b1;
        end else begin
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_write = v.isWrite;
            d_req   = 1'b1;
        end
        waitReady(v.isFetch, lat, wrCnt, wrAddr, wrData, wrongReady, busyEarly);
        if_req = 1'b0;
        d_req  = 1'b0;
        checkOutput($sformatf("v%0d latency", idx), 16'(lat), 16'd3);
        checkOutput($sformatf("v%0d data", idx), v.isFetch ? if_data : d_rdata, v.expData);
        checkOutput($sformatf("v%0d write cycles", idx), 16'(wrCnt), v.isWrite ? 16'd1 : 16'd0);
        if (v.isWrite) begin
            checkOutput($sformatf("v%0d write addr", idx), wrAddr, v.addr);
            checkOutput($sformatf("v%0d write data", idx), wrData, v.wdata);
        end
        checkOutput($sformatf("v%0d other ready", idx), 16'(wrongReady), 16'd0);
        checkOutput($sformatf("v%0d busy in issue", idx), {15'd0, busyEarly}, 16'd1);
        checkOutput($sformatf("v%0d busy at ready", idx), {15'd0, busy}, 16'd0);
    endtask

    initial begin
        logic [15:0] expOwner [8];
        logic [15:0] gotOwner;
        int          lat;
        int          wrCnt;
        int          wrongReady;
        int          pulses;
        int          pulseAt;
        logic [15:0] wrAddr;
        logic [15:0] wrData;
        logic        busyEarly;

        for (int a = 0; a < 65536; a++) memory[a] = 16'h0000;
        memory[16'h0010] = 16'hBEEF;
        memory[16'hFFFF] = 16'h00A5;
        memory[16'h0000] = 16'h1111;
        mem_dout = 16'h0000;

        vectors[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vectors[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'hBEEF};
        vectors[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vectors[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5};
        vectors[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111};
        vectors[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 16'h1234};
        vectors[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
        vectors[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};

        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 16'h0000;
        d_req   = 1'b0;
        d_write = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;

        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("reset mem_addr", mem_addr, 16'h0000);
        checkOutput("reset mem_din", mem_din, 16'h0000);
        checkOutput("reset mem_write", {15'd0, mem_write}, 16'd0);
        checkOutput("reset d_rdata", d_rdata, 16'h0000);
        checkOutput("reset if_data", if_data, 16'h0000);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset readies", {14'd0, if_ready, d_ready}, 16'd0);
        reset = 1'b0;

        // Table of single accesses.
        for (int i = 0; i < 8; i++) applyStimulus(i);

        // Contention: both requests held, so the expected order is D,D,D,F,D,D,D,F.
        expOwner = '{16'h000D, 16'h000D, 16'h000D, 16'h000F,
                     16'h000D, 16'h000D, 16'h000D, 16'h000F};
        @(negedge clock);
        memory[16'h0010] = 16'hBEEF;
        if_addr = 16'h0000;
        if_req  = 1'b1;
        d_addr  = 16'h0010;
        d_write = 1'b0;
        d_req   = 1'b1;
        for (int g = 0; g < 8; g++) begin
            gotOwner = 16'h0000;
            for (int c = 0; c < 12; c++) begin
                @(negedge clock);
                if (d_ready && if_ready) gotOwner = 16'h00FF;
                else if (d_ready) gotOwner = 16'h000D;
                else if (if_ready) gotOwner = 16'h000F;
                if (gotOwner != 16'h0000) break;
            end
            checkOutput($sformatf("contention grant%0d owner", g), gotOwner, expOwner[g]);
            if (expOwner[g] == 16'h000F)
                checkOutput($sformatf("contention grant%0d if_data", g), if_data, 16'h1111);
            else
                checkOutput($sformatf("contention grant%0d d_rdata", g), d_rdata, 16'hBEEF);
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // Request dropped the cycle after its grant. The access still completes once.
        @(negedge clock);
        @(negedge clock);
        d_addr  = 16'h0020;
        d_write = 1'b0;
        d_req   = 1'b1;
        @(negedge clock);
        d_req = 1'b0;
        pulses = 0;
        pulseAt = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clock);
            if (d_ready) begin
                pulses++;
                pulseAt = c;
            end
        end
        checkOutput("dropped req pulses", 16'(pulses), 16'd1);
        checkOutput("dropped req latency", 16'(pulseAt), 16'd3);
        checkOutput("dropped req d_rdata", d_rdata, 16'h1234);
        checkOutput("dropped req idle", {15'd0, busy}, 16'd0);

        // Reset during the ISSUE cycle of a store to 0x0030.
        @(negedge clock);
        d_addr  = 16'h0030;
        d_wdata = 16'h7777;
        d_write = 1'b1;
        d_req   = 1'b1;
        @(negedge clock);
        checkOutput("store issue mem_write", {15'd0, mem_write}, 16'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset mem_write", {15'd0, mem_write}, 16'd0);
        checkOutput("async reset mem_addr", mem_addr, 16'h0000);
        checkOutput("async reset mem_din", mem_din, 16'h0000);
        checkOutput("async reset busy", {15'd0, busy}, 16'd0);
        checkOutput("async reset d_rdata", d_rdata, 16'h0000);
        checkOutput("async reset if_data", if_data, 16'h0000);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (d_ready || if_ready || mem_write || busy) pulses++;
        end
        checkOutput("held reset activity", 16'(pulses), 16'd0);
        checkOutput("aborted store memory", memory[16'h0030], 16'h0000);

        // First arbitration happens at the first rising edge after release.
        d_addr  = 16'h0010;
        d_write = 1'b0;
        reset   = 1'b0;
        waitReady(1'b0, lat, wrCnt, wrAddr, wrData, wrongReady, busyEarly);
        d_req = 1'b0;
        checkOutput("post reset latency", 16'(lat), 16'd3);
        checkOutput("post reset d_rdata", d_rdata, 16'hBEEF);
        checkOutput("post reset writes", 16'(wrCnt), 16'd0);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum number of consecutive data grants allowed while a fetch request waits.
REQ-002 The block SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port if_req  input  1  instruction-fetch request; held high until if_ready.
REQ-005 The block SHALL have port if_addr  input  16  fetch address; stable while if_req is high.
REQ-006 The block SHALL have port if_ready  output  1  one-cycle pulse: fetch complete, if_data valid.
REQ-007 The block SHALL have port if_data  output  16  last fetched word.
REQ-008 The block SHALL have port d_req  input  1  data request; held high until d_ready.
REQ-009 The block SHALL have port d_write  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-010 The block SHALL have port d_addr  input  16  data address.
REQ-011 The block SHALL have port d_wdata  input  16  store data.
REQ-012 The block SHALL have port d_ready  output  1  one-cycle pulse: data access complete.
REQ-013 The block SHALL have port d_rdata  output  16  last loaded word.
REQ-014 The block SHALL have port mem_addr  output  16  address to the shared memory.
REQ-015 The block SHALL have port mem_din  output  16  write data to the memory.
REQ-016 The block SHALL have port mem_write  output  1  memory write enable.
REQ-017 The block SHALL have port mem_dout  input  16  memory read data, valid the cycle after the address is presented.
REQ-018 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on any grant, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-020 In IDLE with neither request high, the block SHALL remain in IDLE and leave mem_addr, mem_din and mem_write unchanged/low.
REQ-021 The grant rule in IDLE SHALL be: grant data if d_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT); otherwise grant fetch if if_req=1.
REQ-022 On a grant edge, the block SHALL register mem_addr from the granted address, mem_din from d_wdata (data grant only), and the owner and operation type.
REQ-023 mem_write SHALL be 1 only during ISSUE of a data store, and 0 in every other state and case.
REQ-024 In RESP, the block SHALL capture mem_dout into d_rdata for a load or into if_data for a fetch; a store SHALL leave d_rdata unchanged.
REQ-025 At the edge leaving RESP, the block SHALL assert the owner's ready signal (d_ready or if_ready) for exactly one cycle, coincident with the captured data being valid.
REQ-026 Latency SHALL be a ready pulse 3 cycles after the grant edge (request sampled at edge k, ready high during cycle k+3), with at most one access in flight.
REQ-027 The back-to-back rate SHALL be one access per 3 cycles, with the next arbitration in the IDLE cycle following ready.
REQ-028 starve_cnt (width sufficient for STARVE_LIMIT) SHALL increment, saturating, on each data grant made while if_req=1, and SHALL clear on a fetch grant or on any cycle with if_req=0.
REQ-029 When both requests are high simultaneously and starve_cnt=STARVE_LIMIT, fetch SHALL win; otherwise data SHALL win.
REQ-030 If a requester drops its request mid-transaction, the access SHALL still complete and the ready pulse SHALL still occur.
REQ-031 Requests sampled outside IDLE SHALL be ignored until the next IDLE.
REQ-032 Address arithmetic SHALL be 16-bit passthrough with no offset and no wrap handling; 0xFFFF SHALL be a legal address.

Reset
REQ-033 While reset=1, the block SHALL asynchronously force state=IDLE, starve_cnt=0, mem_write=0, if_ready=0, d_ready=0, busy=0, and mem_addr=mem_din=if_data=d_rdata=0x0000.
REQ-034 Reset asserted mid-access SHALL abort the access with no ready pulse and mem_write dropping immediately, not at the next clock.
REQ-035 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset=0.

Verification
REQ-036 Single load: d_req=1, d_write=0, d_addr=0x0010, memory[0x0010]=0xBEEF -> d_ready pulses 3 cycles later with d_rdata=0xBEEF and mem_write never high.
REQ-037 Store: d_write=1, d_addr=0x0020, d_wdata=0x1234 -> mem_write high exactly one cycle with mem_addr=0x0020 and mem_din=0x1234, then d_ready pulses and d_rdata is unchanged.
REQ-038 Contention: if_req and d_req both held high (fetch at 0x0000) -> grant order D,D,D,F,D,D,D,F with STARVE_LIMIT=3, where each F is followed by an if_ready pulse.
REQ-039 Fetch alone: if_req=1, if_addr=0xFFFF, memory[0xFFFF]=0x00A5 -> if_ready pulses with if_data=0x00A5.
REQ-040 Reset during the ISSUE of a store to 0x0030 -> mem_write falls without waiting for a clock, no d_ready pulses, and all outputs read 0 until reset releases.
REQ-041 Dropped request: d_req deasserted the cycle after its grant -> d_ready still pulses once, and the FSM returns to IDLE.
